idx_unit: RTL and testbench

Parametrised index-register unit for the MU0 indexed-addressing datapath. It holds NIDX index registers, each with a per-register step, and supports load, post-increment and pre-decrement. It drives a combinational effective address to the address mux and a registered wrap flag to the control unit. It updates on the falling clock edge, as the other MU0 datapath registers do.

---
 rtl/idx_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_idx_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/idx_unit.sv
// idx_unit: bank of NIDX index registers for MU0 indexed addressing.
// Each register has its own step. Supported operations are LOAD,
// post-increment and pre-decrement.
// All state changes on the falling clock edge. The reset is asynchronous
// and active-high.
// Optional feature macro MODULO_EN: when defined, it adds per-register
// base/limit registers, the LDBASE/LDLIM ops, and circular reload
// arithmetic. With the macro undefined, arithmetic simply wraps modulo 2^AW.
module idx_unit #(
    parameter int AW   = 12,
    parameter int NIDX = 4,
    parameter int SW   = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            idxce,
    input  logic [2:0]      op,
    input  logic [SELW-1:0] idx_sel,
    input  logic [AW-1:0]   alu12,
    output logic [AW-1:0]   idx_q,
    output logic [AW-1:0]   ea,
    output logic            wrap
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_POSTINC = 3'b010;
    localparam logic [2:0] OP_PREDEC  = 3'b011;
    localparam logic [2:0] OP_LDSTEP  = 3'b100;
    localparam logic [2:0] OP_LDBASE  = 3'b101;
    localparam logic [2:0] OP_LDLIM   = 3'b110;

    // Compared against the select so that an out-of-range select (when
    // NIDX is not a power of two) reads as zero and writes nothing.
    localparam logic [SELW:0] NIDX_W = (SELW + 1)'(NIDX);

    // Per-register state, gathered into arrays for the read mux.
    logic [AW-1:0] idx_arr  [NIDX];
    logic [SW-1:0] step_arr [NIDX];
`ifdef MODULO_EN
    logic [AW-1:0] base_arr  [NIDX];
    logic [AW-1:0] limit_arr [NIDX];
`endif

    logic            sel_valid;
    logic [AW-1:0]   cur_idx;
    logic [SW-1:0]   cur_step;
    logic [AW-1:0]   step_ext;
    logic            step_zero;
    logic [AW:0]     sum_ext;
    logic [AW:0]     diff_ext;
    logic [AW-1:0]   next_inc;
    logic [AW-1:0]   next_dec;
    logic            inc_wrap;
    logic            dec_wrap;
`ifdef MODULO_EN
    logic [AW-1:0]   cur_base;
    logic [AW-1:0]   cur_limit;
    logic [AW:0]     lower_ext;
`endif

    logic            do_load;
    logic            do_inc;
    logic            do_dec;
    logic            do_ldstep;
`ifdef MODULO_EN
    logic            do_ldbase;
    logic            do_ldlim;
`endif

    logic            wrap_reg;

    assign sel_valid = ({1'b0, idx_sel} < NIDX_W);

    // Operation decode. NOP, reserved and (without modulo) the base/limit
    // ops leave every strobe low.
    always_comb begin
        do_load   = 1'b0;
        do_inc    = 1'b0;
        do_dec    = 1'b0;
        do_ldstep = 1'b0;
`ifdef MODULO_EN
        do_ldbase = 1'b0;
        do_ldlim  = 1'b0;
`endif
        if (idxce && sel_valid) begin
            case (op)
                OP_NOP:     ;
                OP_LOAD:    do_load   = 1'b1;
                OP_POSTINC: do_inc    = 1'b1;
                OP_PREDEC:  do_dec    = 1'b1;
                OP_LDSTEP:  do_ldstep = 1'b1;
`ifdef MODULO_EN
                OP_LDBASE:  do_ldbase = 1'b1;
                OP_LDLIM:   do_ldlim  = 1'b1;
`else
                OP_LDBASE:  ;
                OP_LDLIM:   ;
`endif
                default:    ;
            endcase
        end
    end

    // Read mux for the selected register's state.
    always_comb begin
        cur_idx   = '0;
        cur_step  = '0;
`ifdef MODULO_EN
        cur_base  = '0;
        cur_limit = '0;
`endif
        if (sel_valid) begin
            cur_idx   = idx_arr[idx_sel];
            cur_step  = step_arr[idx_sel];
`ifdef MODULO_EN
            cur_base  = base_arr[idx_sel];
            cur_limit = limit_arr[idx_sel];
`endif
        end
    end

    // Next-value arithmetic for increment and decrement. It is done at
    // AW+1 bits so that carry, borrow and limit comparisons are exact.
    // A zero step never reports a wrap.
    always_comb begin
        step_ext  = AW'(cur_step);
        step_zero = (cur_step == '0);
        sum_ext   = {1'b0, cur_idx} + {1'b0, step_ext};
        diff_ext  = {1'b0, cur_idx} - {1'b0, step_ext};
`ifdef MODULO_EN
        lower_ext = {1'b0, cur_base} + {1'b0, step_ext};
        inc_wrap  = !step_zero && (sum_ext > {1'b0, cur_limit});
        dec_wrap  = !step_zero && ({1'b0, cur_idx} < lower_ext);
        next_inc  = inc_wrap ? cur_base  : sum_ext[AW-1:0];
        next_dec  = dec_wrap ? cur_limit : diff_ext[AW-1:0];
`else
        inc_wrap  = !step_zero && sum_ext[AW];
        dec_wrap  = !step_zero && diff_ext[AW];
        next_inc  = sum_ext[AW-1:0];
        next_dec  = diff_ext[AW-1:0];
`endif
    end

    // One slice per index register. Only the selected slice loads.
    genvar gi;
    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_reg
            logic          hit;
            logic [AW-1:0] idx_reg;
            logic [SW-1:0] step_reg;

            assign hit = (idx_sel == SELW'(gi));

            // Index value: load, post-increment or pre-decrement.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    idx_reg <= '0;
                end else if (hit) begin
                    if (do_load) begin
                        idx_reg <= alu12;
                    end else if (do_inc) begin
                        idx_reg <= next_inc;
                    end else if (do_dec) begin
                        idx_reg <= next_dec;
                    end
                end
            end

            // Step value. It resets to 1 so that a plain increment works
            // without any set-up.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    step_reg <= SW'(1);
                end else if (hit && do_ldstep) begin
                    step_reg <= alu12[SW-1:0];
                end
            end

            assign idx_arr[gi]  = idx_reg;
            assign step_arr[gi] = step_reg;

`ifdef MODULO_EN
            logic [AW-1:0] base_reg;
            logic [AW-1:0] limit_reg;

            // Circular-buffer bounds. After reset they span the full
            // address range.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    base_reg  <= '0;
                    limit_reg <= '1;
                end else if (hit) begin
                    if (do_ldbase) begin
                        base_reg <= alu12;
                    end
                    if (do_ldlim) begin
                        limit_reg <= alu12;
                    end
                end
            end

            assign base_arr[gi]  = base_reg;
            assign limit_arr[gi] = limit_reg;
`endif
        end
    endgenerate

    // Wrap flag. It is high for exactly the cycle after a wrapping commit.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= (do_inc && inc_wrap) || (do_dec && dec_wrap);
        end
    end

    assign idx_q = cur_idx;
    assign ea    = do_dec ? next_dec : cur_idx;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_idx_unit.sv
// Directed testbench for idx_unit. The DUT updates on the falling edge.
// Inputs are driven just after the rising edge. Combinational outputs are
// checked 1 time unit after driving. Committed state is checked 1 time
// unit after the falling edge.
module tb_idx_unit;

    localparam int AW   = 12;
    localparam int NIDX = 4;
    localparam int SW   = 4;
    localparam int SELW = 2;

    logic            clk;
    logic            rst;
    logic            idxce;
    logic [2:0]      op;
    logic [SELW-1:0] idx_sel;
    logic [AW-1:0]   alu12;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   ea;
    logic            wrap;

    int checks   = 0;
    int failures = 0;

    idx_unit #(.AW(AW), .NIDX(NIDX), .SW(SW), .SELW(SELW)) dut (
        .clk     (clk),
        .rst     (rst),
        .idxce   (idxce),
        .op      (op),
        .idx_sel (idx_sel),
        .alu12   (alu12),
        .idx_q   (idx_q),
        .ea      (ea),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("t=%0t check %s observed=0x%0h expected=0x%0h", $time, tag, obs, exp);
    endtask

    task automatic drive(input logic ce, input logic [2:0] o, input logic [SELW-1:0] s, input logic [AW-1:0] d);
        @(posedge clk);
        idxce   = ce;
        op      = o;
        idx_sel = s;
        alu12   = d;
        #1;
    endtask

    task automatic commit();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; idxce = 1'b0; op = 3'b000; idx_sel = '0; alu12 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_idx_q", idx_q, 12'h000);
        check("reset_ea", ea, 12'h000);
        check("reset_wrap", wrap, 1'b0);

        // Reset in the middle of a POSTINC stream on register 0
        @(posedge clk); rst = 1'b0; idxce = 1'b1; op = 3'b010; idx_sel = 2'd0; #1;
        commit();
        commit();
        @(posedge clk); #1;
        check("stream_ea_before_rst", ea, 12'h002);
        rst = 1'b1; #1;
        check("async_rst_idx_q", idx_q, 12'h000);
        check("async_rst_ea", ea, 12'h000);
        check("async_rst_wrap", wrap, 1'b0);
        commit();
        check("rst_held_idx_q", idx_q, 12'h000);
        @(posedge clk); rst = 1'b0; #1;
        commit();
        check("postinc_after_rst", idx_q, 12'h001);

        // LOAD sel2 with 0x0FF, then three POSTINCs
        drive(1'b1, 3'b001, 2'd2, 12'h0FF); commit();
        drive(1'b1, 3'b010, 2'd2, 12'h000);
        check("pi_ea0", ea, 12'h0FF); commit();
        drive(1'b1, 3'b010, 2'd2, 12'h000);
        check("pi_ea1", ea, 12'h100); commit();
        drive(1'b1, 3'b010, 2'd2, 12'h000);
        check("pi_ea2", ea, 12'h101); commit();
        check("pi_final", idx_q, 12'h102);
        check("pi_nowrap", wrap, 1'b0);
        drive(1'b0, 3'b000, 2'd1, 12'h000);
        check("other_sel1", idx_q, 12'h000);
        drive(1'b0, 3'b000, 2'd3, 12'h000);
        check("other_sel3", idx_q, 12'h000);
        drive(1'b0, 3'b000, 2'd0, 12'h000);
        check("other_sel0", idx_q, 12'h001);

        // Wrap at the top on increment, then at the bottom on decrement (sel1)
        drive(1'b1, 3'b001, 2'd1, 12'hFFE); commit();
        drive(1'b1, 3'b100, 2'd1, 12'h002); commit();
        drive(1'b1, 3'b010, 2'd1, 12'h000);
        check("wrapinc_ea", ea, 12'hFFE); commit();
        check("wrapinc_idx", idx_q, 12'h000);
        check("wrapinc_flag", wrap, 1'b1);
        drive(1'b1, 3'b100, 2'd1, 12'h001);
        check("wrap_held_cycle", wrap, 1'b1); commit();
        check("wrap_cleared", wrap, 1'b0);
        drive(1'b1, 3'b011, 2'd1, 12'h000);
        check("wrapdec_ea", ea, 12'hFFF); commit();
        check("wrapdec_idx", idx_q, 12'hFFF);
        check("wrapdec_flag", wrap, 1'b1);

        // idxce=0 blocks the op; a zero step leaves the register unchanged
        drive(1'b0, 3'b001, 2'd1, 12'h555);
        check("ce0_ea", ea, 12'hFFF); commit();
        check("ce0_idx", idx_q, 12'hFFF);
        check("ce0_wrap_clear", wrap, 1'b0);
        drive(1'b1, 3'b100, 2'd1, 12'h000); commit();
        drive(1'b1, 3'b010, 2'd1, 12'h000);
        check("step0_ea", ea, 12'hFFF); commit();
        check("step0_idx", idx_q, 12'hFFF);
        check("step0_wrap", wrap, 1'b0);
        drive(1'b1, 3'b011, 2'd1, 12'h000);
        check("step0_dec_ea", ea, 12'hFFF); commit();
        check("step0_dec_wrap", wrap, 1'b0);

        // Reserved op 111 changes nothing (sel0 holds 0x001)
        drive(1'b1, 3'b111, 2'd0, 12'h777); commit();
        check("rsvd_idx", idx_q, 12'h001);
        check("rsvd_wrap", wrap, 1'b0);

`ifdef MODULO_EN
        // Circular buffer 0x100..0x103 on sel3
        drive(1'b1, 3'b101, 2'd3, 12'h100); commit();
        drive(1'b1, 3'b110, 2'd3, 12'h103); commit();
        drive(1'b1, 3'b001, 2'd3, 12'h103); commit();
        drive(1'b1, 3'b010, 2'd3, 12'h000);
        check("mod_inc_ea", ea, 12'h103); commit();
        check("mod_inc_idx", idx_q, 12'h100);
        check("mod_inc_wrap", wrap, 1'b1);
        drive(1'b1, 3'b011, 2'd3, 12'h000);
        check("mod_dec_ea", ea, 12'h103); commit();
        check("mod_dec_idx", idx_q, 12'h103);
        check("mod_dec_wrap", wrap, 1'b1);
`else
        // Without modulo support, ops 101/110 are NOPs (sel3 idx=0, step=1)
        drive(1'b1, 3'b101, 2'd3, 12'h123); commit();
        check("ldbase_nop_idx", idx_q, 12'h000);
        drive(1'b1, 3'b110, 2'd3, 12'h00F); commit();
        check("ldlim_nop_idx", idx_q, 12'h000);
        drive(1'b1, 3'b010, 2'd3, 12'h000);
        check("nomod_inc_ea", ea, 12'h000); commit();
        check("nomod_inc_idx", idx_q, 12'h001);
        check("nomod_inc_wrap", wrap, 1'b0);
`endif

        drive(1'b0, 3'b000, 2'd0, 12'h000); commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #20000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
